// File: rtl/sdp_ram_stream_reader.sv
// Burst read engine for a simple dual-port synchronous RAM: issues reads against reserved
// buffer credits, absorbs the fixed RAM latency and replays the words as a valid/ready stream.
`timescale 1ns/1ps

module sdp_ram_stream_reader #(
    parameter int DATA_W     = 64,
    parameter int RAM_DEPTH  = 512,
    parameter int RD_LATENCY = 2,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int ADDR_W    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_rst,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
        $error("sdp_ram_stream_reader: RD_LATENCY must be 1 or 2");
    end
    if ((FIFO_DEPTH < RD_LATENCY + 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sdp_ram_stream_reader: FIFO_DEPTH must be a power of two >= RD_LATENCY+1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       addr;
    logic [LEN_W-1:0]        remaining;
    logic [RD_LATENCY-1:0]   vld_p;
    logic [RD_LATENCY-1:0]   last_p;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [DATA_W-1:0]       fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last;

    logic issue;
    logic issue_last;
    logic tail_vld;
    logic tail_last;
    logic push;
    logic pop;
    logic head_last;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(RAM_DEPTH - 1)) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    // Registered occupancy only: a read is issued solely when its FIFO slot is already reserved.
    function automatic logic has_credit(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] infl);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, cnt} + {1'b0, infl};
        return sum < SUM_W'(FIFO_DEPTH);
    endfunction

    assign issue      = (state == ISSUE) && has_credit(fifo_count, inflight);
    assign issue_last = (remaining == LEN_W'(1));
    assign tail_vld   = vld_p[RD_LATENCY-1];
    assign tail_last  = last_p[RD_LATENCY-1];
    assign push       = tail_vld;
    assign dout_valid = (fifo_count != '0);
    assign pop        = dout_valid && dout_ready;
    assign head_last  = fifo_last[rd_ptr];

    assign dout      = dout_valid ? fifo_data[rd_ptr] : '0;
    assign dout_last = dout_valid && head_last;
    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign ram_en    = busy;
    assign ram_addr  = addr;
    assign ram_rst   = rst;

    // Command FSM: address/length bookkeeping for the issue side
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr      <= cmd_addr;
                        remaining <= cmd_len;
                        if (cmd_len != '0) begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr      <= next_addr(addr);
                        remaining <= remaining - 1'b1;
                        if (issue_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head_last && (inflight == '0) && (fifo_count == CNT_W'(1))) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In-flight stage: valid shift register mirrors the RAM read pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p    <= '0;
            inflight <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
            inflight <= inflight + CNT_W'(issue) - CNT_W'(tail_vld);
        end
    end

    always_ff @(posedge clk) begin
        last_p[0] <= issue && issue_last;
        for (int i = 1; i < RD_LATENCY; i++) begin
            last_p[i] <= last_p[i-1];
        end
    end

    // Output FIFO stage: pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= ram_dout;
            fifo_last[wr_ptr] <= tail_last;
        end
    end

endmodule

// File: tb/tb_sdp_ram_stream_reader.sv
// Directed bench for sdp_ram_stream_reader: one instance per RAM latency, each with a behavioural RAM.
`timescale 1ns/1ps

module tb_sdp_ram_stream_reader;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        cmd_valid;
    logic [8:0]  cmd_addr;
    logic [15:0] cmd_len;
    logic        dout_ready;
    logic        sel_ll;

    logic        cmd_ready_a, ram_en_a, ram_rst_a, dout_valid_a, dout_last_a, busy_a;
    logic [8:0]  ram_addr_a;
    logic [63:0] ram_dout_a, dout_a;
    logic        cmd_ready_b, ram_en_b, ram_rst_b, dout_valid_b, dout_last_b, busy_b;
    logic [8:0]  ram_addr_b;
    logic [63:0] ram_dout_b, dout_b;

    logic        cmd_valid_a, cmd_valid_b;
    logic [63:0] mem [512];
    logic [63:0] q1_a, q2_a, q1_b;

    int cyc = 0;
    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cmd_valid_a = cmd_valid && !sel_ll;
    assign cmd_valid_b = cmd_valid && sel_ll;

    sdp_ram_stream_reader #(.DATA_W(64), .RAM_DEPTH(512), .RD_LATENCY(2), .LEN_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_addr(ram_addr_a), .ram_en(ram_en_a),
        .ram_rst(ram_rst_a), .ram_dout(ram_dout_a), .dout(dout_a), .dout_valid(dout_valid_a),
        .dout_ready(dout_ready), .dout_last(dout_last_a), .busy(busy_a)
    );

    sdp_ram_stream_reader #(.DATA_W(64), .RAM_DEPTH(512), .RD_LATENCY(1), .LEN_W(16), .FIFO_DEPTH(4)) dut_ll (
        .clk(clk), .rst(rst_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_addr(ram_addr_b), .ram_en(ram_en_b),
        .ram_rst(ram_rst_b), .ram_dout(ram_dout_b), .dout(dout_b), .dout_valid(dout_valid_b),
        .dout_ready(dout_ready), .dout_last(dout_last_b), .busy(busy_b)
    );

    // Behavioural RAM read ports: two-register and one-register output pipelines
    always @(posedge clk) begin
        if (ram_rst_a) begin
            q1_a <= '0;
            q2_a <= '0;
        end else if (ram_en_a) begin
            q1_a <= mem[ram_addr_a];
            q2_a <= q1_a;
        end
        if (ram_rst_b) begin
            q1_b <= '0;
        end else if (ram_en_b) begin
            q1_b <= mem[ram_addr_b];
        end
    end
    assign ram_dout_a = q2_a;
    assign ram_dout_b = q1_b;

    logic        obs_ready, obs_en, obs_valid, obs_last, obs_busy, obs_rrst;
    logic [8:0]  obs_addr;
    logic [63:0] obs_dout;
    assign obs_ready = sel_ll ? cmd_ready_b  : cmd_ready_a;
    assign obs_en    = sel_ll ? ram_en_b     : ram_en_a;
    assign obs_valid = sel_ll ? dout_valid_b : dout_valid_a;
    assign obs_last  = sel_ll ? dout_last_b  : dout_last_a;
    assign obs_busy  = sel_ll ? busy_b       : busy_a;
    assign obs_rrst  = sel_ll ? ram_rst_b    : ram_rst_a;
    assign obs_addr  = sel_ll ? ram_addr_b   : ram_addr_a;
    assign obs_dout  = sel_ll ? dout_b       : dout_a;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_cmd_ready"}, 64'(obs_ready), 64'd0);
        check_val({tag, "_ram_en"}, 64'(obs_en), 64'd0);
        check_val({tag, "_ram_addr"}, 64'(obs_addr), 64'd0);
        check_val({tag, "_ram_rst"}, 64'(obs_rrst), 64'd1);
        check_val({tag, "_dout_valid"}, 64'(obs_valid), 64'd0);
        check_val({tag, "_dout_last"}, 64'(obs_last), 64'd0);
        check_val({tag, "_dout"}, obs_dout, 64'd0);
        check_val({tag, "_busy"}, 64'(obs_busy), 64'd0);
    endtask

    // One command; dout_ready follows an on/off pattern. Timing and address checks only when ready stays high.
    task automatic run_burst(input string tag, input int addr, input int len, input int on, input int off);
        int t0, got, lat, occ, max_occ;
        bit timing;
        lat     = sel_ll ? 1 : 2;
        timing  = (off == 0);
        got     = 0;
        max_occ = 0;
        @(posedge clk); #1;
        cmd_addr  = 9'(addr);
        cmd_len   = 16'(len);
        cmd_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        check_val({tag, "_cmd_ready"}, 64'(obs_ready), 64'd1);
        for (int i = 0; i < 400 && got < len; i++) begin
            @(posedge clk); #1;
            cmd_valid  = 1'b0;
            dout_ready = ((i % (on + off)) < on);
            @(negedge clk);
            occ = sel_ll ? (int'(dut_ll.fifo_count) + int'(dut_ll.inflight))
                         : (int'(dut.fifo_count) + int'(dut.inflight));
            if (occ > max_occ) max_occ = occ;
            if (cyc == t0 + 1) begin
                check_val({tag, "_ram_en"}, 64'(obs_en), 64'd1);
            end
            if (timing && (cyc - t0) >= 1 && (cyc - t0) <= len) begin
                check_val({tag, "_ram_addr"}, 64'(obs_addr), 64'((addr + cyc - t0 - 1) % 512));
            end
            if (obs_valid && dout_ready) begin
                check_val({tag, "_data"}, obs_dout, 64'((addr + got) % 512));
                check_val({tag, "_last"}, 64'(obs_last), 64'(got == len - 1));
                if (timing) begin
                    check_val({tag, "_cycle"}, 64'(cyc - t0), 64'(2 + lat + got));
                end
                got++;
            end
        end
        check_val({tag, "_count"}, 64'(got), 64'(len));
        check_val({tag, "_credit"}, 64'(max_occ <= 4), 64'd1);
        @(posedge clk); #1;
        dout_ready = 1'b1;
        @(negedge clk);
        check_val({tag, "_done_ready"}, 64'(obs_ready), 64'd1);
        check_val({tag, "_done_valid"}, 64'(obs_valid), 64'd0);
        check_val({tag, "_done_busy"}, 64'(obs_busy), 64'd0);
    endtask

    task automatic run_zero_len();
        bit seen_en, seen_valid;
        seen_en    = 1'b0;
        seen_valid = 1'b0;
        @(posedge clk); #1;
        cmd_addr   = 9'd7;
        cmd_len    = 16'd0;
        cmd_valid  = 1'b1;
        dout_ready = 1'b1;
        @(negedge clk);
        check_val("zl_hs_ready", 64'(obs_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            if (i == 0) check_val("zl_next_ready", 64'(obs_ready), 64'd1);
            seen_en    |= obs_en;
            seen_valid |= obs_valid;
        end
        check_val("zl_ram_en", 64'(seen_en), 64'd0);
        check_val("zl_dout_valid", 64'(seen_valid), 64'd0);
    endtask

    task automatic run_reset_mid();
        int  v;
        bit  found;
        found = 1'b0;
        @(posedge clk); #1;
        cmd_addr   = 9'd40;
        cmd_len    = 16'd16;
        cmd_valid  = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            if (obs_valid) begin
                found = 1'b1;
                v = cyc;
            end
        end
        check_val("rm_first_valid", 64'(found), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(negedge clk);
        check_val("rm_assert_cycle", 64'(cyc - v), 64'd3);
        check_reset_outputs("rm");
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        check_val("rm_release_ready", 64'(obs_ready), 64'd1);
        check_val("rm_release_valid", 64'(obs_valid), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 64'(i);
        rst_a      = 1'b1;
        rst_b      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        dout_ready = 1'b0;
        sel_ll     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check_val("rel_cmd_ready", 64'(obs_ready), 64'd1);
        check_val("rel_ram_rst", 64'(obs_rrst), 64'd0);
        check_val("rel_ram_en", 64'(obs_en), 64'd0);

        run_burst("basic", 10, 5, 1, 0);
        run_burst("wrap", 510, 4, 1, 0);
        run_burst("bp", 0, 16, 1, 3);
        run_zero_len();
        run_burst("after_zl", 3, 1, 1, 0);
        run_reset_mid();
        run_burst("post_rst", 100, 2, 1, 0);

        sel_ll = 1'b1;
        run_burst("ll", 0, 8, 1, 0);
        run_burst("ll_bp", 508, 9, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/sdp_ram_stream_reader.md
# sdp_ram_stream_reader

Read-side engine for a simple dual-port synchronous RAM: accepts a burst read command (start address, word count), drives the RAM read port (address, enable, output reset), absorbs the RAM's fixed read latency and re-presents the words as a valid/ready stream with a last flag. It sits between a `sdp_sync_ram` read port and any downstream consumer that may apply backpressure. It guarantees no word is lost, because it only issues reads for which buffer space is reserved.

## Interface
- `DATA_W`, 64: RAM word width (`NB_COL*COL_WIDTH` of the attached RAM).
- `RAM_DEPTH`, 512: RAM entries. Address width is `bw(RAM_DEPTH)` from `GLOBAL_PARAM`.
- `RD_LATENCY`, 2: RAM read latency in cycles. 1 = LOW_LATENCY RAM, 2 = HIGH_PERFORMANCE RAM. Other values are illegal.
- `LEN_W`, 16: width of the command length field.
- `FIFO_DEPTH`, 4: output buffer entries. Must be >= `RD_LATENCY+1`, a power of two.

Ports:
- `clk` in 1: clock, shared with the RAM.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command accepted when high with `cmd_valid`.
- `cmd_addr` in `bw(RAM_DEPTH)`: start address.
- `cmd_len` in `LEN_W`: number of words to read; 0 is legal.
- `ram_addr` out `bw(RAM_DEPTH)`: connects to RAM `addrb`.
- `ram_en` out 1: connects to RAM `enb`.
- `ram_rst` out 1: connects to RAM `rstb`.
- `ram_dout` in `DATA_W`: connects to RAM `doutb`.
- `dout` out `DATA_W`: stream data.
- `dout_valid` out 1: stream valid.
- `dout_ready` in 1: stream ready from consumer.
- `dout_last` out 1: high with the final word of a command.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States are IDLE, ISSUE and DRAIN.
- **IDLE:**
  - `cmd_ready=1`.
  - On the `cmd_valid` handshake, latch the address and length.
  - If `cmd_len=0`, stay in IDLE. No reads are issued and no output is produced.
  - Otherwise go to ISSUE.
- **ISSUE:**
  - Each cycle, issue one read if `fifo_count + inflight < FIFO_DEPTH`.
  - On issue: present `ram_addr`, increment the address modulo `RAM_DEPTH` (`RAM_DEPTH-1` wraps to 0), decrement the remaining count.
  - When the last address has been issued, go to DRAIN.
- **DRAIN:**
  - Wait until inflight = 0, the FIFO is empty, and the last word has been handshaken.
  - Then go to IDLE.
- **In-flight tracking:**
  - A `RD_LATENCY`-deep valid shift register tracks in-flight reads, together with a parallel last-tag shift register.
  - When the tail of the shift register is valid, `ram_dout` is written into the FIFO along with its last tag.
- **RAM enable:**
  - `ram_en=1` whenever `busy=1`. This keeps the RAM output pipeline advancing, so the latency is fixed.
  - `ram_en=0` in IDLE.
  - `ram_rst` is held at 0 except during reset, when it is 1.
- **Output stream:**
  - `dout` and `dout_last` come from the FIFO head. `dout_valid` means the FIFO is not empty.
  - A word pops on `dout_valid & dout_ready`.
  - `dout_last` is high only on the final word of the command.
- **Simultaneous events:** a FIFO push and pop in the same cycle leave `fifo_count` unchanged. The credit check uses the registered `fifo_count` and inflight values, so it is conservative.

## Timing
- Reset values: `cmd_ready=0` while `rst` is high and 1 in the first IDLE cycle after release. `ram_en=0`, `ram_addr=0`, `ram_rst=1` during reset and 0 after. `dout_valid=0`, `dout_last=0`, `dout=0`, `busy=0`.
- Command handshake in cycle T:
  - The first `ram_addr` and `ram_en` are presented in T+1.
  - The first `dout_valid` appears in T+2+`RD_LATENCY`.
- A read issued in cycle C lands in the FIFO at the end of C+`RD_LATENCY` and is visible on `dout` in C+`RD_LATENCY`+1.
- With `dout_ready` held high, one word is issued and one delivered per cycle. There are no bubbles after the first word.
- Backpressure: the issue rate drops to zero once the credits are exhausted. Issuing resumes in the cycle after a pop.
- `cmd_ready` rises in the cycle after the `dout_last` handshake.
- Reset asserted mid-operation clears the state machine, the shift registers and the FIFO immediately. In-flight RAM data is discarded.

## Test plan
- **Basic burst:** `RD_LATENCY=2`, RAM preloaded with mem[i]=i, command (addr 10, len 5), `dout_ready=1` -> `dout` 10..14 on consecutive cycles, first word at T+4, `dout_last` on 14, `cmd_ready` high in the cycle after.
- **Wrap:** `RAM_DEPTH=512`, command (addr 510, len 4) -> words 510, 511, 0, 1; `ram_addr` wraps 511→0.
- **Backpressure:** command (addr 0, len 16), `dout_ready` toggling 1 cycle on / 3 off -> all 16 words in order with none dropped or duplicated; `fifo_count + inflight` never exceeds 4.
- **Zero length:** command with len 0 -> no `ram_en` pulse, no `dout_valid`, `cmd_ready` high the next cycle; a following command (addr 3, len 1) returns word 3 with `dout_last`=1.
- **Low latency:** `RD_LATENCY=1`, command (addr 0, len 8) -> first word at T+3, then 8 words back-to-back.
- **Reset mid-burst:** assert `rst` 3 cycles after `dout_valid` first rises -> all outputs return to reset values in the same cycle; after release, command (addr 100, len 2) returns 100, 101 correctly.
